tt_um_jleugeri_ttt_scheduler: RTL and testbench
===============================================

TT_UM_JLEUGERI_TTT_SCHEDULER -- requirements
Module: tt_um_jleugeri_ttt_scheduler

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 10: number of processors addressed; PID_W = $clog2(NUM_PROCESSORS).
REQ-002 SHALL have parameter NEW_TOKENS_BITS, default 4: signed width of token increments and buffers.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- hold  in  1  blocks stage advance while high
- done  out  1  current stage work complete
- stage  out  stage_t  current stage
- in_valid, in_last  in  1,1  external token beat / final beat
- in_ready  out  1  beat accepted
- in_id  in  PID_W  external target
- in_good, in_bad  in  NEW_TOKENS_BITS signed  external tokens
- rec_valid, rec_last  in  1,1  recurrent beat / final beat; no backpressure
- rec_id  in  PID_W  recurrent target
- rec_good, rec_bad  in  NEW_TOKENS_BITS signed  recurrent tokens
- upd_valid  out  1  processor update strobe
- upd_id  out  PID_W  processor being updated
- upd_good, upd_bad  out  NEW_TOKENS_BITS signed  buffered tokens
- upd_startstop  in  2  processor result, one cycle after upd_valid
- out_valid  out  1  output beat; out_ready  in  1  consumer accept
- out_id  out  PID_W; out_startstop  out  2
- bad_id  out  1  sticky: id >= NUM_PROCESSORS seen

Function
REQ-005 SHALL leave a stage on the clock edge where done=1 and hold=0; order RESET->INPUT->RECURRENT->UPDATE->OUTPUT->INPUT.
REQ-006 SHALL keep done high and perform no further work while hold=1 after completion.
REQ-007 RESET: done=1 on the first cycle after reset deasserts.
REQ-008 SHALL clear all good/bad buffers on the edge entering INPUT.
REQ-009 INPUT: in_ready = !done; on in_valid&&in_ready add in_good/in_bad to buffer[in_id]; done rises the cycle after an accepted beat with in_last.
REQ-010 RECURRENT: every rec_valid beat accumulates identically; done rises the cycle after a beat with rec_last; rec_* ignored in all other stages.
REQ-011 Accumulation SHALL saturate to [-2^(NEW_TOKENS_BITS-1), 2^(NEW_TOKENS_BITS-1)-1] independently for good and bad.
REQ-012 Beats with id >= NUM_PROCESSORS SHALL be consumed without buffer change and set bad_id.
REQ-013 UPDATE: upd_valid for ids 0..N-1, one per consecutive cycle, with that id's buffers; upd_startstop stored per id one cycle later; done after id N-1 result is stored (N+1 cycles).
REQ-014 OUTPUT: scan ids ascending; emit only ids with startstop != 0; out_valid/out_id/out_startstop stable until out_ready; at most one beat per cycle; zero-startstop ids cost one cycle each; done the cycle after the scan passes N-1.
REQ-015 SHALL drive in_ready, upd_valid and out_valid low outside their own stage.

Reset
REQ-016 Reset SHALL win over any simultaneous event and may arrive in any stage.
REQ-017 On reset: stage=RESET, done=0, in_ready=0, upd_valid=0, out_valid=0, upd_id=0, out_id=0, upd_good/bad=0, out_startstop=0, bad_id=0, all buffers and stored startstop=0, scan counters=0.

Structure
REQ-018 stage_t (RESET, INPUT, RECURRENT, UPDATE, OUTPUT) and the saturating signed-add function SHALL live in package tt_um_jleugeri_ttt.
REQ-019 The buffer array SHALL be a sub-module tt_um_jleugeri_ttt_token_buffer: clear, one accumulate port, one read port; no other sub-modules.

Verification (NUM_PROCESSORS=10, NEW_TOKENS_BITS=4)
REQ-020 Reset release, hold=0 -> RESET 1 cycle, done=1, then INPUT with all buffers 0.
REQ-021 INPUT beats id3 (+2,-1), id3 (+3,0) last; RECURRENT rec id3 (+1,0) last -> UPDATE shows id3 good=6, bad=-1, other ids 0.
REQ-022 Five beats id0 good=+7 -> buffer clamps at +7; five beats bad=-8 -> clamps at -8.
REQ-023 upd_startstop=2'b01 for id2, 2'b10 for id7, else 0; out_ready low 3 cycles -> exactly two beats (2,01) then (7,10), each stable while stalled.
REQ-024 hold=1 at INPUT completion -> done stays 1, in_ready 0, stage unchanged until hold=0; in_id=12 -> bad_id=1 and no buffer change.
REQ-025 reset during UPDATE at id5 -> next cycle stage=RESET, every output at REQ-017 values.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared types and arithmetic for the token scheduler.
package tt_um_jleugeri_ttt;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    INPUT     = 3'd1,
    RECURRENT = 3'd2,
    UPDATE    = 3'd3,
    OUTPUT    = 3'd4
  } stage_t;

  // Signed add of two sign-extended operands, clamped to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_token_buffer.sv
// Per-processor good/bad token buffers with clear, one accumulate and one read port.
module tt_um_jleugeri_ttt_token_buffer
  import tt_um_jleugeri_ttt::*;
#(
  parameter int unsigned NUM_PROCESSORS  = 10,
  parameter int unsigned NEW_TOKENS_BITS = 4,
  localparam int unsigned PID_W = $clog2(NUM_PROCESSORS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              acc_en,
  input  logic [PID_W-1:0]                  acc_id,
  input  logic signed [NEW_TOKENS_BITS-1:0] acc_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] acc_bad,
  input  logic [PID_W-1:0]                  rd_id,
  output logic signed [NEW_TOKENS_BITS-1:0] rd_good_c,
  output logic signed [NEW_TOKENS_BITS-1:0] rd_bad_c
);

  logic signed [NEW_TOKENS_BITS-1:0] good_q [NUM_PROCESSORS];
  logic signed [NEW_TOKENS_BITS-1:0] good_d [NUM_PROCESSORS];
  logic signed [NEW_TOKENS_BITS-1:0] bad_q  [NUM_PROCESSORS];
  logic signed [NEW_TOKENS_BITS-1:0] bad_d  [NUM_PROCESSORS];

  // Clear wins over accumulate; an id outside the array matches no entry.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
      if (clear) begin
        good_d[i] = '0;
        bad_d[i]  = '0;
      end else if (acc_en && (acc_id == PID_W'(i))) begin
        good_d[i] = NEW_TOKENS_BITS'(sat_add(32'(good_q[i]), 32'(acc_good), NEW_TOKENS_BITS));
        bad_d[i]  = NEW_TOKENS_BITS'(sat_add(32'(bad_q[i]), 32'(acc_bad), NEW_TOKENS_BITS));
      end
    end
  end

  // Read mux over the stored buffers.
  always_comb begin
    rd_good_c = '0;
    rd_bad_c  = '0;
    for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
      if (rd_id == PID_W'(i)) begin
        rd_good_c = good_q[i];
        rd_bad_c  = bad_q[i];
      end
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
        good_q[i] <= '0;
        bad_q[i]  <= '0;
      end
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Stage scheduler: gathers tokens, updates processors, streams non-zero results.
module tt_um_jleugeri_ttt_scheduler
  import tt_um_jleugeri_ttt::*;
#(
  parameter int unsigned NUM_PROCESSORS  = 10,
  parameter int unsigned NEW_TOKENS_BITS = 4,
  localparam int unsigned PID_W = $clog2(NUM_PROCESSORS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              hold,
  output logic                              done,
  output stage_t                            stage,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  input  logic [PID_W-1:0]                  in_id,
  input  logic signed [NEW_TOKENS_BITS-1:0] in_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] in_bad,
  input  logic                              rec_valid,
  input  logic                              rec_last,
  input  logic [PID_W-1:0]                  rec_id,
  input  logic signed [NEW_TOKENS_BITS-1:0] rec_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] rec_bad,
  output logic                              upd_valid,
  output logic [PID_W-1:0]                  upd_id,
  output logic signed [NEW_TOKENS_BITS-1:0] upd_good,
  output logic signed [NEW_TOKENS_BITS-1:0] upd_bad,
  input  logic [1:0]                        upd_startstop,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PID_W-1:0]                  out_id,
  output logic [1:0]                        out_startstop,
  output logic                              bad_id
);

  localparam int unsigned     PID_W1  = PID_W + 1;
  localparam logic [PID_W:0]  NUM_P   = PID_W1'(NUM_PROCESSORS);
  localparam logic [PID_W-1:0] LAST_ID = PID_W'(NUM_PROCESSORS - 1);

  stage_t                            stage_q, stage_d;
  logic                              done_q, done_d;
  logic                              in_ready_q, in_ready_d;
  logic                              upd_valid_q, upd_valid_d;
  logic [PID_W-1:0]                  upd_id_q, upd_id_d;
  logic signed [NEW_TOKENS_BITS-1:0] upd_good_q, upd_good_d;
  logic signed [NEW_TOKENS_BITS-1:0] upd_bad_q, upd_bad_d;
  logic                              store_valid_q, store_valid_d;
  logic [PID_W-1:0]                  store_id_q, store_id_d;
  logic [1:0]                        ss_q [NUM_PROCESSORS];
  logic [1:0]                        ss_d [NUM_PROCESSORS];
  logic                              out_valid_q, out_valid_d;
  logic [PID_W-1:0]                  out_id_q, out_id_d;
  logic [1:0]                        out_ss_q, out_ss_d;
  logic [PID_W-1:0]                  scan_q, scan_d;
  logic                              bad_id_q, bad_id_d;

  logic                              buf_clear, acc_en;
  logic [PID_W-1:0]                  acc_id, rd_id;
  logic signed [NEW_TOKENS_BITS-1:0] acc_good, acc_bad, rd_good_c, rd_bad_c;
  logic                              in_id_ok, rec_id_ok;
  logic [1:0]                        scan_ss;

  assign in_id_ok  = {1'b0, in_id} < NUM_P;
  assign rec_id_ok = {1'b0, rec_id} < NUM_P;

  tt_um_jleugeri_ttt_token_buffer #(
    .NUM_PROCESSORS (NUM_PROCESSORS),
    .NEW_TOKENS_BITS(NEW_TOKENS_BITS)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (buf_clear),
    .acc_en   (acc_en),
    .acc_id   (acc_id),
    .acc_good (acc_good),
    .acc_bad  (acc_bad),
    .rd_id    (rd_id),
    .rd_good_c(rd_good_c),
    .rd_bad_c (rd_bad_c)
  );

  // Stored startstop of the id currently under the output scan.
  always_comb begin
    scan_ss = 2'b00;
    for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
      if (scan_q == PID_W'(i)) scan_ss = ss_q[i];
    end
  end

  // Next-state and output logic for all stages.
  always_comb begin
    stage_d       = stage_q;
    done_d        = done_q;
    in_ready_d    = 1'b0;
    upd_valid_d   = 1'b0;
    upd_id_d      = upd_id_q;
    upd_good_d    = upd_good_q;
    upd_bad_d     = upd_bad_q;
    store_valid_d = upd_valid_q;
    store_id_d    = upd_id_q;
    ss_d          = ss_q;
    out_valid_d   = out_valid_q;
    out_id_d      = out_id_q;
    out_ss_d      = out_ss_q;
    scan_d        = scan_q;
    bad_id_d      = bad_id_q;
    buf_clear     = 1'b0;
    acc_en        = 1'b0;
    acc_id        = in_id;
    acc_good      = in_good;
    acc_bad       = in_bad;
    rd_id         = '0;

    // Processor result lands one cycle after its update strobe.
    if (store_valid_q) begin
      for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
        if (store_id_q == PID_W'(i)) ss_d[i] = upd_startstop;
      end
    end

    if (done_q && !hold) begin
      done_d = 1'b0;
      unique case (stage_q)
        RESET, OUTPUT: begin
          stage_d    = INPUT;
          buf_clear  = 1'b1;
          in_ready_d = 1'b1;
        end
        INPUT:     stage_d = RECURRENT;
        RECURRENT: begin
          stage_d     = UPDATE;
          upd_valid_d = 1'b1;
          upd_id_d    = '0;
          upd_good_d  = rd_good_c;
          upd_bad_d   = rd_bad_c;
        end
        UPDATE: begin
          stage_d     = OUTPUT;
          scan_d      = '0;
          out_valid_d = 1'b0;
        end
        default: ;
      endcase
    end else if (!done_q) begin
      unique case (stage_q)
        RESET: done_d = 1'b1;
        INPUT: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            if (in_id_ok) acc_en = 1'b1;
            else          bad_id_d = 1'b1;
            if (in_last) begin
              done_d     = 1'b1;
              in_ready_d = 1'b0;
            end
          end
        end
        RECURRENT: begin
          acc_id   = rec_id;
          acc_good = rec_good;
          acc_bad  = rec_bad;
          if (rec_valid) begin
            if (rec_id_ok) acc_en = 1'b1;
            else           bad_id_d = 1'b1;
            if (rec_last) done_d = 1'b1;
          end
        end
        UPDATE: begin
          if (upd_valid_q && (upd_id_q != LAST_ID)) begin
            upd_valid_d = 1'b1;
            upd_id_d    = upd_id_q + PID_W'(1);
            rd_id       = upd_id_q + PID_W'(1);
            upd_good_d  = rd_good_c;
            upd_bad_d   = rd_bad_c;
          end
          if (store_valid_q && (store_id_q == LAST_ID)) done_d = 1'b1;
        end
        OUTPUT: begin
          if (out_valid_q) begin
            if (out_ready) begin
              out_valid_d = 1'b0;
              if (scan_q == LAST_ID) done_d = 1'b1;
              else                   scan_d = scan_q + PID_W'(1);
            end
          end else if (scan_ss != 2'b00) begin
            out_valid_d = 1'b1;
            out_id_d    = scan_q;
            out_ss_d    = scan_ss;
          end else if (scan_q == LAST_ID) begin
            done_d = 1'b1;
          end else begin
            scan_d = scan_q + PID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q       <= RESET;
      done_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_id_q      <= '0;
      upd_good_q    <= '0;
      upd_bad_q     <= '0;
      store_valid_q <= 1'b0;
      store_id_q    <= '0;
      for (int i = 0; i < int'(NUM_PROCESSORS); i++) ss_q[i] <= 2'b00;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_ss_q      <= 2'b00;
      scan_q        <= '0;
      bad_id_q      <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      done_q        <= done_d;
      in_ready_q    <= in_ready_d;
      upd_valid_q   <= upd_valid_d;
      upd_id_q      <= upd_id_d;
      upd_good_q    <= upd_good_d;
      upd_bad_q     <= upd_bad_d;
      store_valid_q <= store_valid_d;
      store_id_q    <= store_id_d;
      ss_q          <= ss_d;
      out_valid_q   <= out_valid_d;
      out_id_q      <= out_id_d;
      out_ss_q      <= out_ss_d;
      scan_q        <= scan_d;
      bad_id_q      <= bad_id_d;
    end
  end

  assign stage         = stage_q;
  assign done          = done_q;
  assign in_ready      = in_ready_q;
  assign upd_valid     = upd_valid_q;
  assign upd_id        = upd_id_q;
  assign upd_good      = upd_good_q;
  assign upd_bad       = upd_bad_q;
  assign out_valid     = out_valid_q;
  assign out_id        = out_id_q;
  assign out_startstop = out_ss_q;
  assign bad_id        = bad_id_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Directed scoreboard bench for the token scheduler (10 processors, 4-bit tokens).
module tb_tt_um_jleugeri_ttt_scheduler;
  import tt_um_jleugeri_ttt::*;

  localparam int N  = 10;
  localparam int W  = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, hold, done;
  stage_t              stage;
  logic                in_valid, in_last, in_ready;
  logic [PW-1:0]       in_id;
  logic signed [W-1:0] in_good, in_bad;
  logic                rec_valid, rec_last;
  logic [PW-1:0]       rec_id;
  logic signed [W-1:0] rec_good, rec_bad;
  logic                upd_valid;
  logic [PW-1:0]       upd_id;
  logic signed [W-1:0] upd_good, upd_bad;
  logic [1:0]          upd_startstop;
  logic                out_valid, out_ready;
  logic [PW-1:0]       out_id;
  logic [1:0]          out_startstop;
  logic                bad_id;

  tt_um_jleugeri_ttt_scheduler #(.NUM_PROCESSORS(N), .NEW_TOKENS_BITS(W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .done(done), .stage(stage),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .in_id(in_id),
    .in_good(in_good), .in_bad(in_bad),
    .rec_valid(rec_valid), .rec_last(rec_last), .rec_id(rec_id),
    .rec_good(rec_good), .rec_bad(rec_bad),
    .upd_valid(upd_valid), .upd_id(upd_id), .upd_good(upd_good), .upd_bad(upd_bad),
    .upd_startstop(upd_startstop),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_startstop(out_startstop), .bad_id(bad_id)
  );

  typedef struct { int id; int g; int b; } upd_t;
  typedef struct { int id; int ss; } out_t;

  upd_t       upd_q[$];
  out_t       out_q[$];
  int         mg[N];
  int         mb[N];
  logic [1:0] ss_pat[N];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(input int v);
    if (v > 7)  return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  task automatic model_acc(input int id, input int g, input int b);
    if (id < N) begin
      mg[id] = clamp(mg[id] + g);
      mb[id] = clamp(mb[id] + b);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mg[i] = 0;
      mb[i] = 0;
      ss_pat[i] = 2'b00;
    end
  endtask

  task automatic in_beat(input int id, input int g, input int b, input bit last);
    chk("in_ready_before_beat", in_ready, 1);
    in_valid = 1'b1; in_id = 4'(id); in_good = 4'(g); in_bad = 4'(b); in_last = last;
    model_acc(id, g, b);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    if (last) begin
      chk("input_done", done, 1);
      chk("input_ready_after_last", in_ready, 0);
    end
  endtask

  task automatic rec_beat(input int id, input int g, input int b, input bit last);
    rec_valid = 1'b1; rec_id = 4'(id); rec_good = 4'(g); rec_bad = 4'(b); rec_last = last;
    model_acc(id, g, b);
    tick();
    rec_valid = 1'b0; rec_last = 1'b0;
    if (last) chk("rec_done", done, 1);
  endtask

  task automatic advance(input stage_t nxt);
    chk("advance_done_before", done, 1);
    tick();
    chk("advance_stage", stage, nxt);
    chk("advance_done_after", done, 0);
  endtask

  task automatic run_update(input int stop_at);
    logic [1:0] pending;
    int cyc;
    int beats;
    upd_t e;
    pending = 2'b00; cyc = 0; beats = 0;
    for (int i = 0; i < N; i++) begin
      upd_q.push_back('{i, mg[i], mb[i]});
      if (ss_pat[i] != 2'b00) out_q.push_back('{i, int'(ss_pat[i])});
    end
    chk("upd_in_stage_in_ready", in_ready, 0);
    while (!done && cyc < 40) begin
      upd_startstop = pending;
      pending = 2'b00;
      if (upd_valid) begin
        if (upd_q.size() == 0) chk("upd_extra_beat", upd_valid, 0);
        else begin
          e = upd_q.pop_front();
          chk("upd_id", upd_id, e.id);
          chk("upd_good", upd_good, e.g);
          chk("upd_bad", upd_bad, e.b);
          pending = ss_pat[e.id];
          beats++;
          if (e.id == stop_at) return;
        end
      end
      tick();
      cyc++;
    end
    upd_startstop = 2'b00;
    chk("upd_done_seen", done, 1);
    chk("upd_cycles", cyc, N + 1);
    chk("upd_beats", beats, N);
  endtask

  task automatic run_output();
    int cyc;
    int beats;
    int stall;
    int exp_beats;
    logic [PW-1:0] hid;
    logic [1:0] hss;
    out_t o;
    cyc = 0; beats = 0; stall = 0; exp_beats = out_q.size();
    hid = '0; hss = 2'b00;
    chk("out_stage_upd_valid", upd_valid, 0);
    while (!done && cyc < 80) begin
      if (out_valid) begin
        if (stall == 0) begin
          hid = out_id; hss = out_startstop;
        end else begin
          chk("out_stable_id", out_id, hid);
          chk("out_stable_ss", out_startstop, hss);
        end
        if (stall < 3) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          if (out_q.size() == 0) chk("out_extra_beat", out_valid, 0);
          else begin
            o = out_q.pop_front();
            chk("out_id", out_id, o.id);
            chk("out_ss", out_startstop, o.ss);
          end
          beats++;
          stall = 0;
        end
      end else out_ready = 1'b0;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("out_done_seen", done, 1);
    chk("out_beats", beats, exp_beats);
    chk("out_queue_empty", out_q.size(), 0);
    if (exp_beats == 0) chk("out_scan_cycles", cyc, N);
  endtask

  task automatic check_reset_state();
    chk("rst_stage", stage, RESET);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_upd_id", upd_id, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_upd_good", upd_good, 0);
    chk("rst_upd_bad", upd_bad, 0);
    chk("rst_out_ss", out_startstop, 0);
    chk("rst_bad_id", bad_id, 0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_id = '0; in_good = '0; in_bad = '0;
    rec_valid = 1'b0; rec_last = 1'b0; rec_id = '0; rec_good = '0; rec_bad = '0;
    upd_startstop = 2'b00; out_ready = 1'b0;
    clear_model();
    tick();
    tick();
    check_reset_state();

    // Reset release: one RESET cycle with done, then INPUT.
    reset = 1'b0;
    tick();
    chk("post_rst_stage", stage, RESET);
    chk("post_rst_done", done, 1);
    tick();
    chk("enter_input_stage", stage, INPUT);
    chk("enter_input_ready", in_ready, 1);
    chk("enter_input_upd_valid", upd_valid, 0);
    chk("enter_input_out_valid", out_valid, 0);

    // Round 1: basic accumulation across INPUT and RECURRENT.
    in_beat(3, 2, -1, 1'b0);
    in_beat(3, 3, 0, 1'b1);
    advance(RECURRENT);
    rec_beat(3, 1, 0, 1'b1);
    advance(UPDATE);
    run_update(-1);
    advance(OUTPUT);
    run_output();
    advance(INPUT);
    clear_model();

    // Round 2: saturation, stray recurrent traffic, bad id, hold.
    chk("bad_id_clean", bad_id, 0);
    rec_valid = 1'b1; rec_id = 4'd5; rec_good = 4'sd3; rec_bad = 4'sd3; rec_last = 1'b1;
    for (int i = 0; i < 5; i++) in_beat(0, 7, -8, 1'b0);
    in_beat(9, 1, 1, 1'b0);
    in_beat(12, 5, 5, 1'b0);
    chk("bad_id_set", bad_id, 1);
    hold = 1'b1;
    in_beat(4, -2, 3, 1'b1);
    in_valid = 1'b1; in_id = 4'd4; in_good = 4'sd7; in_bad = 4'sd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_done", done, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stage", stage, INPUT);
    end
    in_valid = 1'b0;
    rec_valid = 1'b0; rec_last = 1'b0;
    hold = 1'b0;
    advance(RECURRENT);
    rec_beat(5, 3, -2, 1'b0);
    tick();
    rec_beat(0, -1, 1, 1'b0);
    rec_beat(12, 1, 1, 1'b0);
    rec_beat(9, 7, 7, 1'b1);
    advance(UPDATE);
    ss_pat[2] = 2'b01;
    ss_pat[7] = 2'b10;
    run_update(-1);
    advance(OUTPUT);
    run_output();
    advance(INPUT);
    clear_model();

    // Round 3: buffers cleared on re-entry, then reset mid-UPDATE.
    in_beat(5, 1, 1, 1'b1);
    advance(RECURRENT);
    rec_beat(5, -2, 0, 1'b1);
    advance(UPDATE);
    run_update(5);
    reset = 1'b1;
    upd_startstop = 2'b00;
    tick();
    check_reset_state();
    upd_q.delete();
    out_q.delete();
    reset = 1'b0;
    tick();
    chk("rerst_done", done, 1);
    tick();
    chk("rerst_stage", stage, INPUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
